// File: rtl/lgn_input_pkg.sv
// lgn_input_pkg
//   Shared definitions for the LGN input packer: default geometry,
//   per-feature threshold table, FSM state encoding and a threshold
//   lookup helper used by the single-feature quantizer.
package lgn_input_pkg;

  localparam int DEF_N_FEAT = 8;
  localparam int DEF_FEAT_W = 16;
  localparam int DEF_QBITS  = 2;
  localparam int DEF_NUM_TH = (1 << DEF_QBITS) - 1;

  // Thresholds per feature, ascending. Stored as int so the table does not
  // depend on the raw feature width chosen by an instance.
  typedef int th_arr_t [DEF_N_FEAT][DEF_NUM_TH];

  localparam th_arr_t TH = '{
    '{-256, 0, 256},
    '{-256, 0, 256},
    '{-256, 0, 256},
    '{-256, 0, 256},
    '{-256, 0, 256},
    '{-256, 0, 256},
    '{-256, 0, 256},
    '{-256, 0, 256}
  };

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_STALL   = 2'd1,
    ST_DISCARD = 2'd2
  } state_t;

  // True when threshold k of feature feat_idx lies strictly below value.
  // Entries outside the table never count, so a wider instance simply
  // saturates at the table's code range.
  function automatic logic th_below(input int feat_idx, input int k, input longint value);
    th_below = 1'b0;
    if (feat_idx >= 0 && feat_idx < DEF_N_FEAT && k >= 0 && k < DEF_NUM_TH)
      th_below = (longint'(TH[feat_idx][k]) < value);
  endfunction

endpackage

// File: rtl/lgn_feat_quant.sv
// lgn_feat_quant
//   Combinational thresholder for one raw feature. The output code is the
//   number of thresholds of feature idx that are strictly below feat.
// Ports:
//   feat  - raw signed feature
//   idx   - feature position within the vector (selects threshold row)
//   code  - quantized code, 0 .. 2^QBITS-1
module lgn_feat_quant
  import lgn_input_pkg::*;
#(
  parameter int N_FEAT = DEF_N_FEAT,
  parameter int FEAT_W = DEF_FEAT_W,
  parameter int QBITS  = DEF_QBITS,
  parameter int IDX_W  = 3
) (
  input  logic signed [FEAT_W-1:0] feat,
  input  logic [IDX_W-1:0]         idx,
  output logic [QBITS-1:0]         code
);

  localparam int NUM_TH = (1 << QBITS) - 1;

  longint            feat_ext;
  logic [NUM_TH-1:0] above;

  assign feat_ext = longint'(feat);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_TH; gi++) begin : g_cmp
      assign above[gi] = th_below(int'(idx), gi, feat_ext);
    end
  endgenerate

  // Population count of the comparator outputs; at most NUM_TH, fits QBITS.
  always_comb begin
    code = '0;
    for (int k = 0; k < NUM_TH; k++)
      code = code + QBITS'(above[k]);
  end

endmodule

// File: rtl/lgn_input_packer.sv
// lgn_input_packer
//   Accepts a stream of raw signed features, quantizes each one against its
//   own threshold row and packs N_FEAT codes into one vector for layer 0.
//   Misframed vectors (s_last early or missing) are dropped and reported.
// Ports:
//   clk, rst           - clock, synchronous active-high reset
//   s_valid/s_ready    - raw feature handshake, s_data feature, s_last end marker
//   m_valid/m_ready    - packed vector handshake, m_data packed codes
//   frame_err          - one-cycle pulse per misframed vector
//   err_cnt            - saturating count of frame errors
module lgn_input_packer
  import lgn_input_pkg::*;
#(
  parameter int N_FEAT = DEF_N_FEAT,
  parameter int FEAT_W = DEF_FEAT_W,
  parameter int QBITS  = DEF_QBITS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [FEAT_W-1:0]       s_data,
  input  logic                    s_last,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [N_FEAT*QBITS-1:0] m_data,
  output logic                    frame_err,
  output logic [7:0]              err_cnt
);

  localparam int VEC_W = N_FEAT * QBITS;
  localparam int IDX_W = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_FEAT - 1);

  state_t           state_reg;
  logic [IDX_W-1:0] idx_reg;
  logic [VEC_W-1:0] asm_reg;
  logic [VEC_W-1:0] out_reg;
  logic             m_valid_reg;
  logic             frame_err_reg;
  logic [7:0]       err_cnt_reg;

  logic [QBITS-1:0] code;
  logic [VEC_W-1:0] asm_with;
  logic             accept;
  logic             drain;
  logic             at_last;
  logic             err_event;

  lgn_feat_quant #(
    .N_FEAT (N_FEAT),
    .FEAT_W (FEAT_W),
    .QBITS  (QBITS),
    .IDX_W  (IDX_W)
  ) u_quant (
    .feat (s_data),
    .idx  (idx_reg),
    .code (code)
  );

  // Assembly register with the current beat's code merged into its slot, so
  // the final beat can be forwarded straight to the output register.
  genvar gi;
  generate
    for (gi = 0; gi < N_FEAT; gi++) begin : g_slot
      assign asm_with[gi*QBITS +: QBITS] =
        (idx_reg == IDX_W'(gi)) ? code : asm_reg[gi*QBITS +: QBITS];
    end
  endgenerate

  // s_ready is held low combinationally during reset so no beat slips in
  // on the reset edge; otherwise it only drops while a vector is stalled.
  assign s_ready   = !rst && (state_reg != ST_STALL);
  assign accept    = s_valid && s_ready;
  assign drain     = m_valid_reg && m_ready;
  assign at_last   = (idx_reg == LAST_IDX);
  assign err_event = accept && (state_reg == ST_COLLECT) && (s_last != at_last);

  assign m_valid   = m_valid_reg;
  assign m_data    = out_reg;
  assign frame_err = frame_err_reg;
  assign err_cnt   = err_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_COLLECT;
      idx_reg       <= '0;
      asm_reg       <= '0;
      out_reg       <= '0;
      m_valid_reg   <= 1'b0;
      frame_err_reg <= 1'b0;
      err_cnt_reg   <= '0;
    end else begin
      frame_err_reg <= err_event;
      if (err_event && err_cnt_reg != 8'hFF)
        err_cnt_reg <= err_cnt_reg + 8'd1;

      // A load below overrides this clear when drain and load coincide.
      if (drain)
        m_valid_reg <= 1'b0;

      unique case (state_reg)
        ST_COLLECT: begin
          if (accept) begin
            if (err_event) begin
              idx_reg <= '0;
              asm_reg <= '0;
              if (at_last)
                state_reg <= ST_DISCARD;
            end else if (at_last) begin
              idx_reg <= '0;
              if (!m_valid_reg || m_ready) begin
                out_reg     <= asm_with;
                m_valid_reg <= 1'b1;
                asm_reg     <= '0;
              end else begin
                asm_reg   <= asm_with;
                state_reg <= ST_STALL;
              end
            end else begin
              asm_reg <= asm_with;
              idx_reg <= idx_reg + IDX_W'(1);
            end
          end
        end
        ST_STALL: begin
          if (drain) begin
            out_reg     <= asm_reg;
            m_valid_reg <= 1'b1;
            asm_reg     <= '0;
            state_reg   <= ST_COLLECT;
          end
        end
        ST_DISCARD: begin
          if (accept && s_last)
            state_reg <= ST_COLLECT;
        end
        default: state_reg <= ST_COLLECT;
      endcase
    end
  end

endmodule
